div_unit: RTL and testbench

Iterative radix-2 integer divider for the Execute stage, implementing RV32M DIV/DIVU/REM/REMU. It is the stall-request producer for the pipeline hazard logic. While a division is in flight it raises `stall_req` so Fetch/Decode/Execute freeze, and it honours the Execute flush so a squashed division is abandoned. The result, tagged with its destination register, is delivered to the Memory stage with a one-cycle `done` pulse.

---
 rtl/div_pkg.sv | 24 ++
 rtl/div_step.sv | 23 ++
 rtl/div_unit.sv | 181 ++++++++++++++++++
 tb/tb_div_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
package div_pkg;

  // Operation encoding as presented by Execute.
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  // Divider control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } div_state_e;

  // RISC-V defined special-case values for the 32-bit datapath.
  localparam int                    DIV_WIDTH    = 32;
  localparam logic [DIV_WIDTH-1:0]  DIV_ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [DIV_WIDTH-1:0]  DIV_INT_MIN  = 32'h8000_0000;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract
// the divisor, keep the difference when it does not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  // One extra bit so the shifted remainder and the trial difference keep
  // their sign; the restored value always fits back into WIDTH bits.
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  assign rem_sh = {rem_i, quo_i[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, divisor_i};
  assign rem_o  = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_o  = {quo_i[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 divider for Execute (DIV/DIVU/REM/REMU).
// Optional build macro: DIV_EARLY_OUT_EN -- divide-by-zero and signed
// overflow skip the iteration phase and finish two cycles after acceptance.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              flush,
  output logic              stall_req,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic [REG_AW-1:0] rd_out
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WIDTH-1:0]  rem_q;
  logic [WIDTH-1:0]  quo_q;
  logic [WIDTH-1:0]  divisor_q;
  logic [WIDTH-1:0]  dividend_q;
  logic              is_rem_q;
  logic              neg_quo_q;
  logic              neg_rem_q;
  logic              div_zero_q;
  logic              ovf_q;
  logic [REG_AW-1:0] rd_q;
  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  result_q;
  logic [REG_AW-1:0] rd_out_q;

  div_op_e           op_e;
  logic              signed_op;
  logic              a_neg;
  logic              b_neg;
  logic              b_zero;
  logic              ovf_in;
  logic              early_out;
  logic              accept;
  logic [WIDTH-1:0]  abs_a;
  logic [WIDTH-1:0]  abs_b;
  logic [WIDTH-1:0]  rem_d;
  logic [WIDTH-1:0]  quo_d;
  logic [WIDTH-1:0]  quo_fix;
  logic [WIDTH-1:0]  rem_fix;
  logic [WIDTH-1:0]  result_d;

  // Operand conditioning: magnitudes are only taken for the signed ops.
  assign op_e      = div_op_e'(op);
  assign signed_op = (op_e == OP_DIV) || (op_e == OP_REM);
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign abs_a     = a_neg ? -a : a;
  assign abs_b     = b_neg ? -b : b;
  assign b_zero    = (b == '0);
  assign ovf_in    = signed_op & (a == INT_MIN) & (b == ALL_ONES);

`ifdef DIV_EARLY_OUT_EN
  assign early_out = b_zero | ovf_in;
`else
  assign early_out = 1'b0;
`endif

  // A start is only taken from IDLE, and never alongside a flush.
  assign accept    = start & ~flush & (state_q == ST_IDLE);
  assign stall_req = accept | (state_q == ST_RUN);

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_q),
    .rem_o     (rem_d),
    .quo_o     (quo_d)
  );

  // Sign fixup and special-case override of the finished iteration.
  always_comb begin
    quo_fix = neg_quo_q ? -quo_q : quo_q;
    rem_fix = neg_rem_q ? -rem_q : rem_q;
    if (div_zero_q) begin
      quo_fix = ALL_ONES;
      rem_fix = dividend_q;
    end else if (ovf_q) begin
      quo_fix = INT_MIN;
      rem_fix = '0;
    end
    result_d = is_rem_q ? rem_fix : quo_fix;
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      divisor_q  <= '0;
      dividend_q <= '0;
      is_rem_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      rd_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      rd_out_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            rem_q      <= '0;
            quo_q      <= abs_a;
            divisor_q  <= abs_b;
            dividend_q <= a;
            cnt_q      <= CNT_W'(WIDTH);
            is_rem_q   <= op[1];
            neg_quo_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            div_zero_q <= b_zero;
            ovf_q      <= ovf_in;
            rd_q       <= rd_in;
            busy_q     <= 1'b1;
            state_q    <= early_out ? ST_FIN : ST_RUN;
          end
        end
        ST_RUN: begin
          if (flush) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          // A squashed op leaves the previous result and tag untouched.
          if (!flush) begin
            result_q <= result_d;
            rd_out_q <= rd_q;
            done_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed and lightly randomised bench for div_unit with a result scoreboard.
module tb_div_unit;
  import div_pkg::*;

  localparam int W  = 32;
  localparam int RA = 5;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [RA-1:0] rd_in;
  logic          flush;
  logic          stall_req;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic [RA-1:0] rd_out;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(W), .REG_AW(RA)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .rd_in     (rd_in),
    .flush     (flush),
    .stall_req (stall_req),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out)
  );

  typedef struct {
    logic [W-1:0]  res;
    logic [RA-1:0] rd;
    int            lat;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [W-1:0]  last_res;
  logic [RA-1:0] last_rd;
  bit            seen;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model written from the RISC-V definitions.
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    int sx, sy;
    sx = x;
    sy = y;
    case (o)
      2'b01:   return (y == 0) ? DIV_ALL_ONES : x / y;
      2'b11:   return (y == 0) ? x : x % y;
      2'b00: begin
        if (y == 0) return DIV_ALL_ONES;
        if (x == DIV_INT_MIN && y == DIV_ALL_ONES) return DIV_INT_MIN;
        return W'(sx / sy);
      end
      default: begin
        if (y == 0) return x;
        if (x == DIV_INT_MIN && y == DIV_ALL_ONES) return '0;
        return W'(sx % sy);
      end
    endcase
  endfunction

  task automatic do_op(input string name, input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [RA-1:0] r,
                       input logic [W-1:0] exp_res, input bit chk_stall);
    exp_t e;
    int   n;
    bit   got;
    bit   stall_ok;
    bit   special;
    special = (y == 0) || ((o == 2'b00 || o == 2'b10) && x == DIV_INT_MIN && y == DIV_ALL_ONES);
    e.res = exp_res;
    e.rd  = r;
    e.lat = (special && EARLY) ? 2 : W + 2;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; rd_in = r;
    sb.push_back(e);
    #1;
    if (chk_stall) chk({name, " stall_at_start"}, W'(stall_req), W'(1));
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; rd_in = RA'($urandom);
    n = 1; got = 1'b0; stall_ok = 1'b1;
    while (!got && n <= 60) begin
      if (done) begin
        got = 1'b1;
      end else begin
        if (chk_stall && (stall_req !== (n <= W))) stall_ok = 1'b0;
        if (chk_stall && n == W + 1) chk({name, " busy_in_fin"}, W'(busy), W'(1));
        @(negedge clk);
        n++;
      end
    end
    chk({name, " done_seen"}, W'(got), W'(1));
    if (got) begin
      chk({name, " sb_depth"}, W'(sb.size()), W'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({name, " result"}, result, e.res);
        chk({name, " rd_out"}, W'(rd_out), W'(e.rd));
        chk({name, " latency"}, W'(n), W'(e.lat));
      end
      if (chk_stall) begin
        chk({name, " stall_during_run"}, W'(stall_ok), W'(1));
        chk({name, " stall_in_done_cycle"}, W'(stall_req), W'(0));
      end
      last_res = result;
      last_rd  = rd_out;
    end else if (sb.size() > 0) begin
      void'(sb.pop_front());
    end
    $display("op %-14s a=%h b=%h rd=%0d -> result=%h rd_out=%0d cycles=%0d",
             name, x, y, r, result, rd_out, n);
  endtask

  initial begin
    logic [1:0] ro;
    logic [W-1:0] rx, ry;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; rd_in = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", W'(busy), W'(0));
    chk("reset done", W'(done), W'(0));
    chk("reset stall_req", W'(stall_req), W'(0));
    chk("reset result", result, W'(0));
    chk("reset rd_out", W'(rd_out), W'(0));
    rst = 1'b0;

    do_op("DIVU 100/7", 2'b01, 32'd100, 32'd7, 5'd1, 32'd14, 1'b1);
    @(negedge clk);
    chk("done pulse width", W'(done), W'(0));
    chk("busy after done", W'(busy), W'(0));
    do_op("REMU 100/7",  2'b11, 32'd100, 32'd7, 5'd2, 32'd2, 1'b0);
    do_op("DIV -7/2",    2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 1'b0);
    do_op("REM -7/2",    2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, 1'b0);
    do_op("REM 7/-2",    2'b10, 32'd7, 32'hFFFF_FFFE, 5'd5, 32'd1, 1'b0);
    do_op("DIVU 5/0",    2'b01, 32'd5, 32'd0, 5'd6, 32'hFFFF_FFFF, 1'b0);
    do_op("REMU 5/0",    2'b11, 32'd5, 32'd0, 5'd7, 32'd5, 1'b0);
    do_op("DIV -5/0",    2'b00, 32'hFFFF_FFFB, 32'd0, 5'd8, 32'hFFFF_FFFF, 1'b0);
    do_op("REM -5/0",    2'b10, 32'hFFFF_FFFB, 32'd0, 5'd9, 32'hFFFF_FFFB, 1'b0);
    do_op("DIV ovf",     2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1'b0);
    do_op("REM ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = (i < 3) ? W'($urandom_range(1, 1000)) : $urandom;
      if (ry == 0) ry = 32'd13;
      do_op("random", ro, rx, ry, RA'(20 + i), model(ro, rx, ry), 1'b0);
    end

    // Flush ten cycles into RUN: op abandoned, outputs keep their values.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd3; rd_in = 5'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_run busy", W'(busy), W'(0));
    chk("flush_run stall_req", W'(stall_req), W'(0));
    seen = 1'b0;
    repeat (40) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    chk("flush_run no_done", W'(seen), W'(0));
    chk("flush_run result_held", result, last_res);
    chk("flush_run rd_held", W'(rd_out), W'(last_rd));
    $display("flush in RUN: busy=%0d result=%h rd_out=%0d", busy, result, rd_out);

    do_op("DIVU 9/3", 2'b01, 32'd9, 32'd3, 5'd12, 32'd3, 1'b0);

    // Flush arriving in the finishing cycle also suppresses the result.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd77; b = 32'd5; rd_in = 5'd30;
    @(negedge clk);
    start = 1'b0;
    repeat (W) @(negedge clk);
    chk("flush_fin in_fin", W'(busy & ~stall_req), W'(1));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    seen = done;
    repeat (5) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    chk("flush_fin no_done", W'(seen), W'(0));
    chk("flush_fin result_held", result, last_res);
    $display("flush in FIN: busy=%0d result=%h rd_out=%0d", busy, result, rd_out);

    // Reset twenty cycles into RUN clears everything.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd12345; b = 32'd17; rd_in = 5'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrun_rst busy", W'(busy), W'(0));
    chk("midrun_rst done", W'(done), W'(0));
    chk("midrun_rst stall_req", W'(stall_req), W'(0));
    chk("midrun_rst result", result, W'(0));
    chk("midrun_rst rd_out", W'(rd_out), W'(0));
    $display("reset in RUN: busy=%0d result=%h rd_out=%0d", busy, result, rd_out);
    rst = 1'b0;

    // Start together with flush is ignored.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd50; b = 32'd5; rd_in = 5'd3;
    #1;
    chk("start_flush stall_req", W'(stall_req), W'(0));
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("start_flush busy", W'(busy), W'(0));
    seen = 1'b0;
    repeat (40) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    chk("start_flush no_done", W'(seen), W'(0));
    $display("start+flush: busy=%0d done_seen=%0d", busy, seen);

    do_op("DIVU 1000/10", 2'b01, 32'd1000, 32'd10, 5'd31, 32'd100, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
